// File: rtl/rom_wave_arb.sv
// rom_wave_arb: round-robin arbiter that shares one waveform ROM between
// several DDS channels. It tracks each read through the ROM latency and
// returns every sample to its owner with a one-hot valid tag.
module rom_wave_arb #(
    parameter int NCH     = 2,
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 8,
    parameter int ROM_LAT = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NCH-1:0]        req,
    input  logic [NCH*ADDR_W-1:0] req_addr,
    output logic [NCH-1:0]        gnt,
    output logic [ADDR_W-1:0]     rom_address,
    input  logic [DATA_W-1:0]     rom_q,
    output logic [NCH-1:0]        rd_valid,
    output logic [DATA_W-1:0]     rd_data
);

    localparam int PTR_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic [PTR_W-1:0]  r_ptr;
    logic [ADDR_W-1:0] r_romAddress;
    logic [NCH-1:0]    r_tag [0:ROM_LAT];
    logic [NCH-1:0]    r_rdValid;
    logic [DATA_W-1:0] r_rdData;

    logic [NCH-1:0]    w_gnt;
    logic [PTR_W-1:0]  w_gntIdx;
    logic [PTR_W-1:0]  w_scanIdx;
    logic [PTR_W-1:0]  w_nextPtr;
    logic              w_xfer;
    logic [ADDR_W-1:0] w_gntAddr;

    // Rotating-priority search: first requester at or above ptr, wrapping to 0
    always_comb begin
        w_gnt     = '0;
        w_gntIdx  = '0;
        w_scanIdx = '0;
        w_xfer    = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            w_scanIdx = PTR_W'((int'(r_ptr) + k) % NCH);
            if (!w_xfer && req[w_scanIdx]) begin
                w_xfer            = 1'b1;
                w_gnt[w_scanIdx]  = 1'b1;
                w_gntIdx          = w_scanIdx;
            end
        end
    end

    // Select the winner's address and the pointer slot just past the winner
    always_comb begin
        w_gntAddr = '0;
        for (int k = 0; k < NCH; k++) begin
            if (w_gnt[k]) begin
                w_gntAddr = req_addr[k*ADDR_W +: ADDR_W];
            end
        end
        w_nextPtr = PTR_W'((int'(w_gntIdx) + 1) % NCH);
    end

    // Launch the granted address to the ROM and rotate priority past the winner
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_romAddress <= '0;
            r_ptr        <= '0;
        end else if (w_xfer) begin
            r_romAddress <= w_gntAddr;
            r_ptr        <= w_nextPtr;
        end
    end

    // Owner tags ride alongside the read; stage 0 mirrors the address register,
    // the remaining ROM_LAT stages mirror the ROM's internal latency
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i <= ROM_LAT; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag[0] <= w_gnt;
            for (int i = 1; i <= ROM_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    // Capture the sample when its tag emerges; hold the data between returns
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rdValid <= '0;
            r_rdData  <= '0;
        end else begin
            r_rdValid <= r_tag[ROM_LAT];
            if (|r_tag[ROM_LAT]) begin
                r_rdData <= rom_q;
            end
        end
    end

    assign gnt         = w_gnt;
    assign rom_address = r_romAddress;
    assign rd_valid    = r_rdValid;
    assign rd_data     = r_rdData;

endmodule

// File: tb/tb_rom_wave_arb.sv
// tb_rom_wave_arb: scoreboard bench for rom_wave_arb with a latency-accurate
// ROM model and a request-level reference model of the arbitration rules.
module tb_rom_wave_arb;

    localparam int NCH     = 4;
    localparam int ADDR_W  = 14;
    localparam int DATA_W  = 8;
    localparam int ROM_LAT = 2;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic [NCH-1:0]        req = '0;
    logic [NCH*ADDR_W-1:0] req_addr;
    logic [NCH-1:0]        gnt;
    logic [ADDR_W-1:0]     rom_address;
    logic [DATA_W-1:0]     rom_q;
    logic [NCH-1:0]        rd_valid;
    logic [DATA_W-1:0]     rd_data;

    logic [ADDR_W-1:0]     chAddr [NCH];
    logic [DATA_W-1:0]     mem [0:16383];
    logic [DATA_W-1:0]     romPipe [0:ROM_LAT-1];

    typedef struct {
        int               ch;
        logic [DATA_W-1:0] data;
        int               due;
    } exp_t;

    exp_t              sb[$];
    int                cyc = 0;
    int                compared = 0;
    int                mismatched = 0;
    int                modelPtr = 0;
    logic [NCH-1:0]    lastXfer = '0;
    logic [ADDR_W-1:0] expAddr = '0;
    logic [DATA_W-1:0] lastData = '0;
    int                waitCnt [NCH];

    always #5 clock = ~clock;

    rom_wave_arb #(
        .NCH(NCH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(ROM_LAT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .req(req),
        .req_addr(req_addr),
        .gnt(gnt),
        .rom_address(rom_address),
        .rom_q(rom_q),
        .rd_valid(rd_valid),
        .rd_data(rd_data)
    );

    // Pack the per-channel stimulus addresses onto the flat address bus
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            req_addr[i*ADDR_W +: ADDR_W] = chAddr[i];
        end
    end

    // Waveform ROM: q shows mem[address] ROM_LAT edges after the address
    always @(posedge clock) begin
        romPipe[0] <= mem[rom_address];
        for (int i = 1; i < ROM_LAT; i++) begin
            romPipe[i] <= romPipe[i-1];
        end
    end
    assign rom_q = romPipe[ROM_LAT-1];

    // Edge counter used to time-stamp expected returns
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [NCH-1:0] oneHot(input int c);
        logic [NCH-1:0] v;
        v = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    // Reference rule: first requesting channel found scanning upward from p
    function automatic int refWinner(input logic [NCH-1:0] r, input int p);
        for (int k = 0; k < NCH; k++) begin
            if (r[(p + k) % NCH]) return (p + k) % NCH;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [ADDR_W-1:0] nextAddr(input int mode, input int ch);
        case (mode)
            1:       return ADDR_W'(16 * (ch + 1));
            2:       return ($urandom_range(1) == 1) ? 14'h3FFF : 14'h0000;
            3:       return 14'h0005;
            default: return ADDR_W'($urandom_range(16383));
        endcase
    endfunction

    // Requester behaviour: a pending request is held until its transfer edge;
    // afterwards each allowed channel re-requests with probability pct
    task automatic applyStimulus(input int cycles, input logic [NCH-1:0] mask,
                                 input int pct, input int mode);
        repeat (cycles) begin
            @(posedge clock);
            #1;
            for (int ch = 0; ch < NCH; ch++) begin
                if (!(req[ch] && !lastXfer[ch])) begin
                    req[ch] = mask[ch] && ($urandom_range(99) < pct);
                    if (req[ch]) chAddr[ch] = nextAddr(mode, ch);
                end
            end
        end
    endtask

    // Reference model: predicts gnt, the address launch, pointer rotation and
    // the owner/data/time of every return; also measures fairness on the DUT
    always @(negedge clock) begin : model
        int w;
        if (reset) begin
            modelPtr = 0;
            sb.delete();
            lastXfer = '0;
            expAddr  = '0;
            for (int ch = 0; ch < NCH; ch++) waitCnt[ch] = 0;
            w = refWinner(req, 0);
            checkOutput("gnt_during_reset", 32'(gnt), (w < 0) ? 32'd0 : 32'(oneHot(w)));
        end else begin
            checkOutput("rom_address", 32'(rom_address), 32'(expAddr));
            w = refWinner(req, modelPtr);
            checkOutput("gnt", 32'(gnt), (w < 0) ? 32'd0 : 32'(oneHot(w)));
            lastXfer = (w < 0) ? '0 : oneHot(w);
            if (w >= 0) begin
                sb.push_back('{ch: w, data: mem[chAddr[w]], due: cyc + 1 + ROM_LAT + 1});
                expAddr  = chAddr[w];
                modelPtr = (w + 1) % NCH;
            end
            for (int ch = 0; ch < NCH; ch++) begin
                if (req[ch] && !gnt[ch]) begin
                    waitCnt[ch]++;
                    checkOutput("fairness_wait_ok", 32'(waitCnt[ch] <= NCH - 1), 32'd1);
                end else begin
                    waitCnt[ch] = 0;
                end
            end
        end
    end

    // Monitor: checks reset values, and pops the scoreboard whenever a
    // return tag appears, checking owner, sample and arrival edge
    always @(negedge clock) begin : monitor
        exp_t e;
        if (reset) begin
            checkOutput("reset_rd_valid", 32'(rd_valid), 32'd0);
            checkOutput("reset_rd_data", 32'(rd_data), 32'd0);
            checkOutput("reset_rom_address", 32'(rom_address), 32'd0);
            lastData = '0;
        end else if (rd_valid != '0) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_rd_valid", 32'(rd_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("rd_valid_tag", 32'(rd_valid), 32'(oneHot(e.ch)));
                checkOutput("rd_data", 32'(rd_data), 32'(e.data));
                checkOutput("rd_latency_edge", 32'(cyc), 32'(e.due));
                lastData = e.data;
            end
        end else begin
            checkOutput("rd_data_hold", 32'(rd_data), 32'(lastData));
            if (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                checkOutput("missing_rd_valid", 32'(rd_valid), 32'(oneHot(e.ch)));
            end
        end
    end

    // Main sequence: directed scenarios first, then randomized traffic,
    // a mid-stream reset, and a drain before the summary
    initial begin
        for (int a = 0; a < 16384; a++) mem[a] = a[7:0];
        mem[16383] = 8'hA5;
        for (int ch = 0; ch < NCH; ch++) chAddr[ch] = '0;

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        $display("[TB] single request on channel 0, address 0x0005");
        applyStimulus(1, 4'b0001, 100, 3);
        applyStimulus(6, 4'b0000, 0, 0);

        $display("[TB] channels 0 and 1 held high");
        applyStimulus(8, 4'b0011, 100, 1);
        applyStimulus(6, 4'b0000, 0, 0);

        $display("[TB] all channels held high");
        applyStimulus(8, 4'b1111, 100, 1);
        applyStimulus(6, 4'b0000, 0, 0);

        $display("[TB] corner addresses on channel 1");
        chAddr[1] = 14'h3FFF;
        applyStimulus(6, 4'b0010, 100, 2);
        applyStimulus(6, 4'b0000, 0, 0);

        $display("[TB] random traffic");
        applyStimulus(400, 4'b1111, 50, 0);
        applyStimulus(150, 4'b1111, 80, 2);

        $display("[TB] reset during back-to-back traffic");
        applyStimulus(4, 4'b1111, 100, 0);
        @(posedge clock);
        #1 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        applyStimulus(60, 4'b1111, 60, 0);

        $display("[TB] draining");
        applyStimulus(NCH + ROM_LAT + 8, 4'b0000, 0, 0);
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
